// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM encoding, wait-counter width and width helpers.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Wait-state counter covers 0..15 extra ACCESS cycles.
    localparam int unsigned CntWidth = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: lanes with a set strobe take the new word, the rest keep the old word.
module apb_strb_merge
    import apb_pkg::*;
#(
    parameter  int unsigned DataWidth = 32,
    localparam int unsigned StrbWidth = strb_width(DataWidth)
) (
    input  logic [DataWidth-1:0] old_word,
    input  logic [DataWidth-1:0] new_word,
    input  logic [StrbWidth-1:0] strb,
    output logic [DataWidth-1:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (strb[b]) begin
                merged_c[8*b +: 8] = new_word[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB4 completer over a bank of word registers with strobed writes, wait states,
// PSLVERR on bad accesses and read-only slots fed live from the fabric.
module apb_completer_regfile
    import apb_pkg::*;
#(
    parameter int unsigned                     DataWidth  = 32,
    parameter int unsigned                     AddrWidth  = 32,
    parameter int unsigned                     NumRegs    = 8,
    parameter int unsigned                     WaitStates = 0,
    parameter logic [NumRegs-1:0]              RoMask     = '0,
    parameter logic [NumRegs*DataWidth-1:0]    ResetVal   = '0
) (
    input  logic                           PCLK,
    input  logic                           reset,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [AddrWidth-1:0]           PADDR,
    input  logic [DataWidth-1:0]           PWDATA,
    input  logic [DataWidth/8-1:0]         PSTRB,
    output logic [DataWidth-1:0]           PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NumRegs*DataWidth-1:0]   RegIn,
    output logic [NumRegs*DataWidth-1:0]   RegOut,
    output logic [NumRegs-1:0]             WrPulse
);

    localparam int unsigned StrbWidth = strb_width(DataWidth);
    localparam int unsigned OffBits   = clog2(StrbWidth);
    localparam int unsigned IdxW      = (NumRegs > 1) ? clog2(NumRegs) : 1;

    apb_state_e           state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 cap_en_c;
    logic                 ready_c;
    logic                 commit_c;

    logic                 wr_q;
    logic                 err_q;
    logic [IdxW-1:0]      idx_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] strb_q;
    logic [NumRegs-1:0]   wr_pulse_q;

    logic [AddrWidth-1:0] idx_full_c;
    logic                 misalign_c;
    logic                 oob_c;
    logic                 ro_hit_c;
    logic                 dec_err_c;

    logic [DataWidth-1:0] reg_view [NumRegs];
    logic [DataWidth-1:0] reg_in_w [NumRegs];
    logic [DataWidth-1:0] merged_c;
    logic [DataWidth-1:0] rd_word_c;

    // Setup-phase decode; the read-only check only applies to in-range indices.
    assign idx_full_c = PADDR >> OffBits;
    assign misalign_c = (PADDR & AddrWidth'(StrbWidth - 1)) != '0;
    assign oob_c      = idx_full_c >= AddrWidth'(NumRegs);
    assign ro_hit_c   = !oob_c && RoMask[idx_full_c[IdxW-1:0]];
    assign dec_err_c  = misalign_c || oob_c || (PWRITE && ro_hit_c);

    always_ff @(posedge PCLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, wait counting and completion strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_en_c = 1'b0;
        ready_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    cap_en_c = 1'b1;
                    cnt_d    = CntWidth'(WaitStates);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntWidth'(1);
                end else begin
                    ready_c  = 1'b1;
                    commit_c = wr_q && !err_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request captured at setup; bus changes during ACCESS do not matter.
    always_ff @(posedge PCLK or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (cap_en_c) begin
            wr_q    <= PWRITE;
            err_q   <= dec_err_c;
            idx_q   <= idx_full_c[IdxW-1:0];
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    apb_strb_merge #(
        .DataWidth (DataWidth)
    ) u_merge (
        .old_word (reg_view[idx_q]),
        .new_word (wdata_q),
        .strb     (strb_q),
        .merged_c (merged_c)
    );

    // Register bank: read-only slots are plain wires from RegIn.
    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        assign reg_in_w[i] = RegIn[i*DataWidth +: DataWidth];
        if (RoMask[i]) begin : g_ro
            assign reg_view[i] = reg_in_w[i];
        end else begin : g_rw
            logic [DataWidth-1:0] q;
            always_ff @(posedge PCLK or negedge reset) begin
                if (!reset) begin
                    q <= ResetVal[i*DataWidth +: DataWidth];
                end else if (commit_c && (idx_q == IdxW'(i))) begin
                    q <= merged_c;
                end
            end
            assign reg_view[i] = q;
        end
        assign RegOut[i*DataWidth +: DataWidth] = reg_view[i];
    end

    always_ff @(posedge PCLK or negedge reset) begin
        if (!reset) begin
            wr_pulse_q <= '0;
        end else if (commit_c) begin
            wr_pulse_q <= NumRegs'(1) << idx_q;
        end else begin
            wr_pulse_q <= '0;
        end
    end

    // Read-only data is taken live in the completion cycle.
    assign rd_word_c = RoMask[idx_q] ? reg_in_w[idx_q] : reg_view[idx_q];

    assign PREADY  = ready_c;
    assign PSLVERR = ready_c && err_q;
    assign PRDATA  = (ready_c && !wr_q && !err_q) ? rd_word_c : '0;
    assign WrPulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Scoreboard bench for apb_completer_regfile: driver queues expected responses from a
// behavioural register model, a negedge monitor pops and compares on PREADY.
module tb_apb_completer_regfile;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NR = 8;
    localparam int unsigned WS = 3;
    localparam logic [NR-1:0] RO = 8'h04;

    function automatic logic [31:0] rv(input int i);
        return 32'h10223343 + 32'(i) * 32'h01000001;
    endfunction

    function automatic logic [NR*DW-1:0] build_rv();
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NR); i++) r[i*DW +: DW] = rv(i);
        return r;
    endfunction

    localparam logic [NR*DW-1:0] RV = build_rv();

    logic              PCLK = 1'b0;
    logic              reset = 1'b1;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [AW-1:0]     PADDR = '0;
    logic [DW-1:0]     PWDATA = '0;
    logic [DW/8-1:0]   PSTRB = '0;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NR*DW-1:0]  RegIn = '0;
    logic [NR*DW-1:0]  RegOut;
    logic [NR-1:0]     WrPulse;

    apb_completer_regfile #(
        .DataWidth  (DW),
        .AddrWidth  (AW),
        .NumRegs    (NR),
        .WaitStates (WS),
        .RoMask     (RO),
        .ResetVal   (RV)
    ) dut (
        .PCLK    (PCLK),
        .reset   (reset),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .RegIn   (RegIn),
        .RegOut  (RegOut),
        .WrPulse (WrPulse)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem   [NR];
    logic [31:0] regin [NR];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [NR-1:0] exp_pulse = '0;
    exp_t        mon_e;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference model: plain address arithmetic and byte replacement.
    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        if (a % 4 != 0) return 1'b1;
        if (a / 4 >= NR) return 1'b1;
        if (wr && RO[a / 4]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model_issue(input logic wr, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.wr    = wr;
        e.err   = exp_err(wr, a);
        e.idx   = 4'(a / 4);
        e.rdata = '0;
        if (!e.err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem[a / 4][8*b +: 8] = d[8*b +: 8];
            end else begin
                e.rdata = RO[a / 4] ? regin[a / 4] : mem[a / 4];
            end
        end
        return e;
    endfunction

    task automatic set_regin(input int k, input logic [31:0] v);
        regin[k] = v;
        RegIn[k*DW +: DW] = v;
    endtask

    function automatic void check_regout(input string name);
        for (int i = 0; i < int'(NR); i++)
            check(name, RegOut[i*DW +: DW], RO[i] ? regin[i] : mem[i]);
    endfunction

    always @(posedge PCLK) cyc++;

    // Monitor: pulse check every cycle, response check whenever PREADY is high.
    always @(negedge PCLK) begin
        if (!reset) begin
            exp_pulse = '0;
        end else begin
            check("wrpulse", 64'(WrPulse), 64'(exp_pulse));
            exp_pulse = '0;
            if (PREADY) begin
                if (sb.size() == 0) begin
                    check("spurious_pready", 64'(PREADY), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pslverr", 64'(PSLVERR), 64'(mon_e.err));
                    if (!mon_e.wr) check("prdata", 64'(PRDATA), 64'(mon_e.rdata));
                    if (mon_e.wr && !mon_e.err) exp_pulse = NR'(1) << mon_e.idx;
                end
            end else begin
                check("pslverr_no_ready", 64'(PSLVERR), 64'd0);
            end
        end
    end

    // One transfer; abort=1 drops PSEL in the first wait state and expects nothing.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit abort, input bit ro_upd,
                        input logic [31:0] ro_val, output int done_cyc);
        int n;
        done_cyc = -1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        if (ro_upd) regin[2] = ro_val;
        if (!abort) sb.push_back(model_issue(wr, a, d, s));
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PWDATA = $urandom;
        PSTRB = 4'($urandom);
        if (ro_upd) RegIn[2*DW +: DW] = ro_val;
        if (abort) begin
            check("abort_wait_ready", 64'(PREADY), 64'd0);
            @(posedge PCLK); #1;
            PSEL = 1'b0; PENABLE = 1'b0;
            @(posedge PCLK); #1;
            check("abort_idle_ready", 64'(PREADY), 64'd0);
            return;
        end
        n = 0;
        while (!PREADY && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        check("wait_cycles", 64'(n), 64'(WS));
        done_cyc = cyc;
        @(posedge PCLK); #1;
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int d1, d2;
        for (int i = 0; i < int'(NR); i++) begin
            mem[i] = rv(i);
            set_regin(i, $urandom);
        end
        #2 reset = 1'b0;
        @(posedge PCLK); @(posedge PCLK); #1;
        check("rst_pready", 64'(PREADY), 64'd0);
        check("rst_pslverr", 64'(PSLVERR), 64'd0);
        check("rst_prdata", 64'(PRDATA), 64'd0);
        check("rst_wrpulse", 64'(WrPulse), 64'd0);
        check_regout("rst_regout");
        reset = 1'b1;
        idle();

        for (int i = 0; i < int'(NR); i++) xfer(1'b0, 32'(i*4), '0, 4'hF, 0, 0, '0, d1);
        idle();

        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'b0101, 0, 0, '0, d1);
        idle();
        check("strb_merge_reg1", 64'(RegOut[DW +: DW]), 64'h11AD33EF);
        xfer(1'b0, 32'h04, '0, 4'h0, 0, 0, '0, d1);
        idle();

        xfer(1'b1, 32'h40, 32'h12345678, 4'hF, 0, 0, '0, d1);
        xfer(1'b0, 32'h06, '0, 4'hF, 0, 0, '0, d1);
        xfer(1'b1, 32'h06, 32'h87654321, 4'hF, 0, 0, '0, d1);
        idle();
        check_regout("err_no_change");

        xfer(1'b0, 32'h08, '0, 4'hF, 0, 1, 32'hCAFE0001, d1);
        xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, '0, d1);
        idle();
        check("ro_regout", 64'(RegOut[2*DW +: DW]), 64'hCAFE0001);

        xfer(1'b1, 32'h0C, 32'h0BADCAFE, 4'hF, 1, 0, '0, d1);
        idle();
        check_regout("abort_no_write");

        xfer(1'b1, 32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, '0, d1);
        xfer(1'b0, 32'h00, '0, 4'h0, 0, 0, '0, d2);
        check("b2b_spacing", 64'(d2 - d1), 64'(2 + WS));
        idle();

        for (int t = 0; t < 200; t++) begin
            logic        wr;
            logic [31:0] a;
            int unsigned sel;
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 11);
            if (sel < 8) a = 32'(sel * 4);
            else if (sel == 8) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
            else if (sel == 9) a = 32'($urandom_range(8, 63) * 4);
            else if (sel == 10) a = 32'h80000000 | 32'($urandom_range(0, 7) * 4);
            else a = 32'h08;
            if ($urandom_range(0, 2) == 0) set_regin(int'($urandom_range(0, 7)), $urandom);
            xfer(wr, a, $urandom, 4'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0), $urandom, d1);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
        check_regout("random_regout");

        // Reset asserted during the completion cycle of a write drops it.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h0BADF00D; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < int'(WS); i++) begin
            @(posedge PCLK); #1;
        end
        check("rst_mid_pre_ready", 64'(PREADY), 64'd1);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < int'(NR); i++) mem[i] = rv(i);
        check("rst_mid_pready", 64'(PREADY), 64'd0);
        check("rst_mid_pslverr", 64'(PSLVERR), 64'd0);
        check("rst_mid_prdata", 64'(PRDATA), 64'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("rst_mid_wrpulse", 64'(WrPulse), 64'd0);
        check_regout("rst_mid_regout");
        reset = 1'b1;
        idle();
        xfer(1'b0, 32'h00, '0, 4'h0, 0, 0, '0, d1);
        idle();
        idle();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
